// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the pipeline register chain
package pipe_pkg;
  localparam int PIPE_MAX_DEPTH = 8;
  function automatic int clog2_occ(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one valid bit plus payload register of the chain
module pipe_reg_stage #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);
  // take the upstream word when advancing; payload only changes on a real word
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      dout  <= RESET_VALUE;
    end else if (adv) begin
      valid <= load;
      if (load) dout <= din;
    end
  end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register chain with bubble collapsing and flush
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2_occ(DEPTH)-1:0] occupancy
);
  localparam int OW = clog2_occ(DEPTH);
  logic [DEPTH-1:0] v, adv, mv, ld;
  logic [WIDTH-1:0] d  [DEPTH];
  logic [WIDTH-1:0] up [DEPTH];
  logic acc, con;
  // ripple the advance permission back from the output; empty stages always accept
  always_comb begin
    logic down;
    mv   = '0;
    adv  = '0;
    ld   = '0;
    down = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      mv[k]  = v[k] & down;
      adv[k] = ~v[k] | mv[k];
      down   = adv[k];
    end
    ld[0] = in_valid & adv[0];
    for (int k = 1; k < DEPTH; k++) ld[k] = mv[k-1];
  end
  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign acc       = in_valid & in_ready;
  assign con       = out_valid & out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up[i] = in_data;
    end else begin : g_tail
      assign up[i] = d[i-1];
    end
    pipe_reg_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
      .clk  (CLK),
      .rst  (RST),
      .flush(flush),
      .adv  (adv[i]),
      .load (ld[i]),
      .din  (up[i]),
      .valid(v[i]),
      .dout (d[i])
    );
  end
  // occupancy tracks accepted minus consumed words; flush and reset empty it
  always_ff @(posedge CLK) begin
    occupancy <= (RST || flush) ? '0 : occupancy + OW'(acc) - OW'(con);
  end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed self-checking bench for DEPTH=3 and DEPTH=4 chains
module tb_pipe_reg_chain;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        r3, v3, r4, v4;
  logic [31:0] d3, d4;
  logic [1:0]  o3;
  logic [2:0]  o4;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(32'h0)) u3 (
    .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(r3),
    .in_data(in_data), .out_valid(v3), .out_ready(out_ready), .out_data(d3), .occupancy(o3)
  );

  pipe_reg_chain #(.WIDTH(32), .DEPTH(4), .RESET_VALUE(32'h0)) u4 (
    .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(r4),
    .in_data(in_data), .out_valid(v4), .out_ready(out_ready), .out_data(d4), .occupancy(o4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick;
      #1;
      chk("rst_ov", v3, 0);
      chk("rst_occ", o3, 0);
      chk("rst_rdy", r3, 1);
      chk("rst_od", d3, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = c < 8;
      in_data  = 32'h10 + c;
      #1;
      chk("strm_rdy", r3, 1);
      chk("strm_ov", v3, (c >= 3 && c < 11) ? 1 : 0);
      if (c >= 3 && c < 11) chk("strm_od", d3, 32'h10 + c - 3);
      chk("strm_occ", o3, c <= 3 ? c : (c <= 8 ? 3 : 11 - c));
      tick;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA + i;
      #1;
      chk("bp_rdy", r3, 1);
      tick;
    end
    in_data = 32'hD;
    #1;
    chk("bp_full_rdy", r3, 0);
    chk("bp_full_occ", o3, 3);
    tick;
    out_ready = 1'b1;
    #1;
    chk("bp_pass_rdy", r3, 1);
    chk("bp_head", d3, 32'hA);
    tick;
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("bp_after_occ", o3, 3);
    chk("bp_after_head", d3, 32'hB);
    tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    #1;
    chk("fl_pre_occ", o3, 2);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_occ", o3, 0);
    chk("fl_ov", v3, 0);
    chk("fl_rdy", r3, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("fl_no55", v3, 0);
      tick;
    end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    in_valid = 1'b1; in_data = 32'h2;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    #1;
    chk("bub_ov", v4, 1);
    chk("bub_od", d4, 32'h1);
    chk("bub_occ", o4, 2);
    chk("bub_rdy", r4, 1);
    out_ready = 1'b1;
    tick;
    #1;
    chk("bub_next_ov", v4, 1);
    chk("bub_next_od", d4, 32'h2);
    tick;
    #1;
    chk("bub_empty_ov", v4, 0);
    chk("bub_empty_occ", o4, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h21 + i;
      tick;
    end
    #1;
    chk("rmid_occ", o3, 3);
    chk("rmid_rdy", r3, 0);
    rst = 1'b1; out_ready = 1'b1; in_data = 32'h24;
    tick;
    #1;
    chk("rmid_ov", v3, 0);
    chk("rmid_od", d3, 0);
    chk("rmid_occ0", o3, 0);
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rmid_stale", v3, 0);
      tick;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised successor to the single-stage inter-stage data registers between CPU datapath phases (ALU result, memory data, instruction).
- A chain of DEPTH registers, each WIDTH bits with a valid bit, driven by a valid/ready handshake.
- Supports stall by back-pressure, bubble collapsing, synchronous flush and an occupancy count.
- Sits between datapath units where one unit may stall, for example the ALU to the data register when memory is busy.

Parameters:
- WIDTH, 32: payload width in bits.
- DEPTH, 2: number of register stages; legal range is 1..8.
- RESET_VALUE, 0: value loaded into every data register on reset or flush.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stages; same-cycle input is discarded.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  chain can accept in_data this cycle.
- in_data  input  WIDTH  payload in.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  payload of stage DEPTH-1, driven directly from the register.
- occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset: while RST=1 at a clock edge, all stage valids go to 0, all data registers go to RESET_VALUE, and occupancy goes to 0.
  - Outputs after reset: out_valid=0, out_data=RESET_VALUE, in_ready=1.
  - RST has priority over flush and over any handshake.
- Stage numbering: stage 0 is nearest the input, stage DEPTH-1 drives the outputs.
- Move conditions:
  - mv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For stage k, adv[k] = ~v[k] | mv[k], where mv[k] means stage k's content leaves this cycle.
  - mv[k] = v[k] & adv[k+1] for k < DEPTH-1.
  - in_ready = adv[0].
- Ready path: in_ready is combinational from out_ready and the valids, giving a ripple path of length DEPTH. This is accepted.
- Stage update at the edge:
  - If adv[k], stage k loads from its upstream (stage k-1, or in_data for stage 0).
    - v[k] takes upstream valid & upstream-moves; for stage 0 this is in_valid & in_ready.
    - The data register loads only when the incoming valid is 1; otherwise it holds its old value.
  - If not adv[k], stage k holds.
- Bubble collapsing: an empty stage always accepts, so gaps close while the output is stalled.
- Latency: DEPTH cycles from an accepted input to out_valid when out_ready=1 throughout.
- Throughput: 1 word per cycle.
- Capacity: holds DEPTH words when the output is stalled.
- Flush: when flush=1 and RST=0:
  - All valids clear to 0 and data registers load RESET_VALUE.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - out_ready handshakes that complete in the same cycle still count as consumed by the downstream side.
- Occupancy update: occupancy(next) = occupancy + accept - consume.
  - It is the registered popcount of the valids.
  - Simultaneous accept and consume leaves it unchanged.
  - Flush or reset sets it to 0.
- Full: occupancy=DEPTH and out_ready=0 gives in_ready=0, and the producer must hold.
- Full with out_ready=1: in_ready=1, so an item enters while another leaves.
- Empty: out_valid=0 and out_data holds the last loaded value. The consumer must ignore out_data.
- Ordering: strictly FIFO; no reordering or duplication.
- DEPTH=1 with the output stalled: behaves as the legacy single-stage register gated by handshake.

Decomposition:
- Shared package pipe_pkg holds:
  - PIPE_MAX_DEPTH = 8.
  - A function clog2_occ(depth) for the occupancy width.
- Sub-module pipe_reg_stage (one valid + data register, with adv/load/flush inputs), instantiated DEPTH times in a generate loop.
- The top level holds the adv/mv chain and the occupancy counter.

Test Plan:
- Reset release, DEPTH=3, WIDTH=32:
  - Stimulus: hold RST for 2 cycles with in_valid=1.
  - Required: out_valid=0, occupancy=0, in_ready=1, out_data=0 throughout reset.
- Streaming:
  - Stimulus: DEPTH=3, out_ready=1, in_data=0x10..0x17 on consecutive cycles.
  - Required: out_data=0x10 with out_valid=1 exactly 3 cycles after the first accept, then one word per cycle in order; occupancy steady at 3.
- Back-pressure:
  - Stimulus: DEPTH=3, out_ready=0, push 0xA,0xB,0xC,0xD.
  - Required: 0xA–0xC accepted, in_ready=0 when 0xD is offered, occupancy=3.
  - Then raise out_ready for one cycle: 0xA is consumed, 0xD is accepted in the same cycle, and occupancy stays 3.
- Bubble collapse:
  - Stimulus: DEPTH=4, insert 0x1, idle 2 cycles, insert 0x2, with out_ready=0.
  - Required: both words end in stages 3 and 2, occupancy=2, in_ready=1.
- Flush mid-stream:
  - Stimulus: occupancy=2 and flush=1 with in_valid=1, in_data=0x55.
  - Required: next cycle occupancy=0, out_valid=0, and 0x55 never appears at the output.
- Reset mid-operation:
  - Stimulus: assert RST while full and out_ready=1.
  - Required: next cycle all valids are 0, out_data=RESET_VALUE, and no stale word is delivered after RST deasserts.
